pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forward controller for the 5-stage RISC-V pipeline (F, D, E, M, W).
- Drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use, branch/jump redirect, instruction-fetch wait and data-memory wait.
- Holds the pipeline in a flushed state for a fixed number of cycles after reset, and keeps stall/flush performance counters.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_forward_unit.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the 5-stage pipeline hazard controller.
//   - state_t        : hazard-controller FSM states (HOLD, RUN, DWAIT)
//   - FWD_*          : operand forward-select encodings for the E stage
//   - REG_ADDR_WIDTH_DEFAULT : default register-index width
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int REG_ADDR_WIDTH_DEFAULT = 5;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      RUN   = 2'd1,
      DWAIT = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_W  = 2'b01;  // operand from writeback result
   localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory-stage ALU result

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Purely combinational operand-forward selector for one E-stage source.
//   Ports:
//     i_en          : forwarding allowed (controller not holding after reset)
//     i_rs          : E-stage source register index
//     i_rd_m        : M-stage destination, i_reg_write_m : M writes the RF
//     i_rd_w        : W-stage destination, i_reg_write_w : W writes the RF
//     o_fwd         : FWD_RF / FWD_W / FWD_M
//   The M result is younger than the W result, so it wins when both match.
//   Register x0 is hard-wired to zero and is never forwarded.
// ---------------------------------------------------------------------------
module forward_unit
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
   input  logic                      i_en,
   input  logic [REG_ADDR_WIDTH-1:0] i_rs,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd_m,
   input  logic                      i_reg_write_m,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd_w,
   input  logic                      i_reg_write_w,
   output logic [1:0]                o_fwd
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs);
   assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs);

   always_comb begin
      o_fwd = FWD_RF;
      if (i_en) begin
         if (w_hit_m) begin
            o_fwd = FWD_M;
         end else if (w_hit_w) begin
            o_fwd = FWD_W;
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall / flush / forward controller for a 5-stage RISC-V pipeline
//   (F, D, E, M, W). Drives the enable (Stall*) and clear (Flush*) inputs of
//   the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//
//   Ports:
//     clk, rst_n              : clock (rising edge), async active-low reset
//     Rs1D, Rs2D              : decode-stage source registers
//     Rs1E, Rs2E, RdE, LoadE  : execute-stage sources, destination, is-load
//     RdM, RegWriteM          : memory-stage destination / RF write
//     RdW, RegWriteW          : writeback-stage destination / RF write
//     PCSrcE                  : branch taken / jump resolved in E
//     imem_ready              : fetch data valid this cycle
//     dmem_req, dmem_ready    : M-stage memory access / completion
//     StallF/D/E/M            : hold the corresponding stage register
//     FlushD/E/W              : clear the corresponding stage register
//     ForwardAE, ForwardBE    : operand forward selects (see pipeline_pkg)
//     state_o                 : FSM state for debug
//     stall_cnt, flush_cnt    : wrapping performance counters
//
//   Memory handshake: a data access is outstanding in any cycle where
//   dmem_req=1 and dmem_ready=0; it completes in the cycle dmem_ready=1, and
//   a request that drops (dmem_req=0) counts as completed. Fetch is valid
//   only in cycles with imem_ready=1; there is no request qualifier on it.
//
//   FSM: HOLD (pipeline flushed for RESET_HOLD cycles after reset),
//        RUN (normal hazard resolution), DWAIT (frozen on data memory).
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
   parameter int RESET_HOLD     = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic                      LoadE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic                      RegWriteM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteW,
   input  logic                      PCSrcE,
   input  logic                      imem_ready,
   input  logic                      dmem_req,
   input  logic                      dmem_ready,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      StallM,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushW,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic [1:0]                state_o,
   output logic [CNT_WIDTH-1:0]      stall_cnt,
   output logic [CNT_WIDTH-1:0]      flush_cnt
);

   // Hold counter only has to reach RESET_HOLD-1.
   localparam int HOLD_CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_HOLD - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;
   logic [CNT_WIDTH-1:0]  r_flush_cnt;

   logic w_dmem_wait;
   logic w_load_use;
   logic w_active;

   // A dropped request is treated as completed, so one term covers both
   // entering DWAIT from RUN and staying in DWAIT.
   assign w_dmem_wait = dmem_req && !dmem_ready;
   assign w_load_use  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_active    = (r_state != HOLD);

   // ---------------- state register + hold counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HOLD;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
      end else if (r_state == HOLD) begin
         r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         HOLD:    w_next_state = (r_hold_cnt == HOLD_LAST) ? RUN : HOLD;
         RUN:     w_next_state = w_dmem_wait ? DWAIT : RUN;
         DWAIT:   w_next_state = w_dmem_wait ? DWAIT : RUN;
         default: w_next_state = HOLD;
      endcase
   end

   // ---------------- output logic ----------------
   // RUN and DWAIT share one priority chain: in DWAIT the freeze persists
   // while the access is outstanding, and the completing cycle falls
   // through to the redirect / load-use / fetch-wait checks.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      case (r_state)
         RUN, DWAIT: begin
            if (w_dmem_wait) begin
               // Freeze F..M; MEM/WB gets a bubble so W does not retire twice.
               StallF = 1'b1;
               StallD = 1'b1;
               StallE = 1'b1;
               StallM = 1'b1;
               FlushW = 1'b1;
            end else if (PCSrcE) begin
               // Redirect: squash the two wrong-path instructions; fetch the target.
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else if (w_load_use) begin
               // One bubble into E while the dependent instruction waits in D.
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end else if (!imem_ready) begin
               StallF = 1'b1;
               FlushD = 1'b1;
            end
         end
         default: begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
         end
      endcase
   end

   // ---------------- performance counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (w_active) begin
         if (StallF) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (FlushD || FlushE) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
   assign state_o   = r_state;

   // ---------------- forwarding ----------------
   forward_unit #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_a (
      .i_en          (w_active),
      .i_rs          (Rs1E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_fwd         (ForwardAE)
   );

   forward_unit #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_b (
      .i_en          (w_active),
      .i_rs          (Rs2E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_fwd         (ForwardBE)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed scenarios plus a randomized run against a behavioural model of
//   the hazard rules. Inputs change on the falling edge; outputs are sampled
//   1 time unit later, well away from the rising edge.
//   Control word layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int RAW        = 5;
   localparam int RESET_HOLD = 4;
   localparam int CNT_WIDTH  = 32;

   localparam logic [6:0] C_HOLD    = 7'b1000110;
   localparam logic [6:0] C_FREEZE  = 7'b1111001;
   localparam logic [6:0] C_BRANCH  = 7'b0000110;
   localparam logic [6:0] C_LOADUSE = 7'b1100010;
   localparam logic [6:0] C_IMEM    = 7'b1000100;
   localparam logic [6:0] C_NONE    = 7'b0000000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [RAW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic LoadE, RegWriteM, RegWriteW, PCSrcE, imem_ready, dmem_req, dmem_ready;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE, state_o;
   logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
   logic [6:0] ctl;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   pipeline_hazard_ctrl #(
      .REG_ADDR_WIDTH (RAW),
      .RESET_HOLD     (RESET_HOLD),
      .CNT_WIDTH      (CNT_WIDTH)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .Rs1D (Rs1D), .Rs2D (Rs2D), .Rs1E (Rs1E), .Rs2E (Rs2E),
      .RdE (RdE), .LoadE (LoadE), .RdM (RdM), .RegWriteM (RegWriteM),
      .RdW (RdW), .RegWriteW (RegWriteW), .PCSrcE (PCSrcE),
      .imem_ready (imem_ready), .dmem_req (dmem_req), .dmem_ready (dmem_ready),
      .StallF (StallF), .StallD (StallD), .StallE (StallE), .StallM (StallM),
      .FlushD (FlushD), .FlushE (FlushE), .FlushW (FlushW),
      .ForwardAE (ForwardAE), .ForwardBE (ForwardBE), .state_o (state_o),
      .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int               m_hold_left;
   bit               m_wait;
   logic [31:0]      m_stall;
   logic [31:0]      m_flush;
   logic [6:0]       exp_ctl;
   logic [1:0]       exp_fa, exp_fb, exp_state;
   logic [6:0]       exp_q[$];

   function automatic logic [1:0] model_fwd(input logic [RAW-1:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic void model_eval();
      if (m_hold_left > 0) begin
         exp_ctl   = C_HOLD;
         exp_fa    = 2'b00;
         exp_fb    = 2'b00;
         exp_state = 2'd0;
      end else begin
         exp_state = m_wait ? 2'd2 : 2'd1;
         if (dmem_req && !dmem_ready)                            exp_ctl = C_FREEZE;
         else if (PCSrcE)                                        exp_ctl = C_BRANCH;
         else if (LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) exp_ctl = C_LOADUSE;
         else if (!imem_ready)                                   exp_ctl = C_IMEM;
         else                                                    exp_ctl = C_NONE;
         exp_fa = model_fwd(Rs1E);
         exp_fb = model_fwd(Rs2E);
      end
   endfunction

   function automatic void model_clock();
      if (m_hold_left > 0) begin
         m_hold_left--;
      end else begin
         m_wait  = dmem_req && !dmem_ready;
         m_stall = m_stall + 32'(exp_ctl[6]);
         m_flush = m_flush + 32'(exp_ctl[2] | exp_ctl[1]);
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
      RdE = '0; RdM = '0; RdW = '0;
      LoadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   // Leaves the bench on a falling edge with the controller in RUN.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (RESET_HOLD) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
      #1;
      n_tests++; if (ctl !== C_HOLD) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_HOLD); end
      n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
      n_tests++; if (ForwardAE !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b want 00", ForwardAE); end
      n_tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < RESET_HOLD; i++) begin
         #1;
         n_tests++; if (ctl !== C_HOLD || state_o !== 2'd0) begin n_fail++; $display("FAIL hold_cycle%0d: got ctl %b state %0d want %b state 0", i, ctl, state_o, C_HOLD); end
         n_tests++; if (ForwardAE !== 2'b00) begin n_fail++; $display("FAIL hold_fwd%0d: got %b want 00", i, ForwardAE); end
         @(negedge clk);
      end
      #1;
      n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL run_state: got %0d want 1", state_o); end
      n_tests++; if (ctl !== C_NONE) begin n_fail++; $display("FAIL run_ctl: got %b want %b", ctl, C_NONE); end
      n_tests++; if (ForwardAE !== 2'b10) begin n_fail++; $display("FAIL run_fwd: got %b want 10", ForwardAE); end
      n_tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL hold_uncounted: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
   endtask

   task automatic test_load_use();
      do_reset();
      LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
      #1;
      n_tests++; if (ctl !== C_LOADUSE) begin n_fail++; $display("FAIL lu_rs1: got %b want %b", ctl, C_LOADUSE); end
      @(negedge clk);
      LoadE = 1'b0;
      #1;
      n_tests++; if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_one_bubble: got %b want %b", ctl, C_NONE); end
      n_tests++; if (stall_cnt !== 1 || flush_cnt !== 1) begin n_fail++; $display("FAIL lu_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt); end
      LoadE = 1'b1; RdE = 5'd9; Rs1D = 5'd0; Rs2D = 5'd9; imem_ready = 1'b0;
      #1;
      n_tests++; if (ctl !== C_LOADUSE) begin n_fail++; $display("FAIL lu_rs2_over_imem: got %b want %b", ctl, C_LOADUSE); end
      @(negedge clk);
      imem_ready = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      n_tests++; if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); end
      @(negedge clk);
      LoadE = 1'b0; imem_ready = 1'b0;
      #1;
      n_tests++; if (ctl !== C_IMEM) begin n_fail++; $display("FAIL imem_wait: got %b want %b", ctl, C_IMEM); end
      @(negedge clk);
      set_idle();
      #1;
      n_tests++; if (stall_cnt !== 3 || flush_cnt !== 3) begin n_fail++; $display("FAIL lu_cnt_total: got %0d/%0d want 3/3", stall_cnt, flush_cnt); end
   endtask

   task automatic test_branch();
      do_reset();
      LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1; imem_ready = 1'b0;
      #1;
      n_tests++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch_wins: got %b want %b", ctl, C_BRANCH); end
      @(negedge clk);
      set_idle();
      #1;
      n_tests++; if (flush_cnt !== 1 || stall_cnt !== 0) begin n_fail++; $display("FAIL branch_cnt: got %0d/%0d want 0/1 (stall/flush)", stall_cnt, flush_cnt); end
   endtask

   task automatic test_data_wait();
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dwait_ctl%0d: got %b want %b", i, ctl, C_FREEZE); end
         n_tests++; if (state_o !== ((i == 0) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL dwait_state%0d: got %0d want %0d", i, state_o, (i == 0) ? 1 : 2); end
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      #1;
      n_tests++; if (ctl !== C_BRANCH || state_o !== 2'd2) begin n_fail++; $display("FAIL dwait_release: got ctl %b state %0d want %b state 2", ctl, state_o, C_BRANCH); end
      @(negedge clk);
      set_idle();
      #1;
      n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL dwait_back_run: got %0d want 1", state_o); end
      n_tests++; if (stall_cnt !== 3 || flush_cnt !== 1) begin n_fail++; $display("FAIL dwait_cnt: got %0d/%0d want 3/1", stall_cnt, flush_cnt); end
      dmem_req = 1'b1;
      @(negedge clk);
      dmem_req = 1'b0;
      #1;
      n_tests++; if (ctl !== C_NONE || state_o !== 2'd2) begin n_fail++; $display("FAIL dwait_req_drop: got ctl %b state %0d want %b state 2", ctl, state_o, C_NONE); end
      @(negedge clk);
      #1;
      n_tests++; if (state_o !== 2'd1 || stall_cnt !== 4) begin n_fail++; $display("FAIL dwait_drop_exit: got state %0d stall %0d want 1/4", state_o, stall_cnt); end
   endtask

   task automatic test_forward();
      do_reset();
      RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7;
      #1;
      n_tests++; if (ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_beats_w: got %b want 10", ForwardAE); end
      RdM = 5'd3;
      #1;
      n_tests++; if (ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w: got %b want 01", ForwardAE); end
      Rs2E = 5'd0; RdM = 5'd0; RdW = 5'd0;
      #1;
      n_tests++; if (ForwardBE !== 2'b00 || ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b/%b want 00/00", ForwardAE, ForwardBE); end
      Rs2E = 5'd3; RdM = 5'd3; RegWriteM = 1'b0; RdW = 5'd3;
      #1;
      n_tests++; if (ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_b_no_mwrite: got %b want 01", ForwardBE); end
      set_idle();
   endtask

   task automatic test_async_reset_dwait();
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_tests++; if (state_o !== 2'd2 || stall_cnt !== 2) begin n_fail++; $display("FAIL areset_pre: got state %0d stall %0d want 2/2", state_o, stall_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (ctl !== C_HOLD || state_o !== 2'd0) begin n_fail++; $display("FAIL areset_ctl: got ctl %b state %0d want %b state 0", ctl, state_o, C_HOLD); end
      n_tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      repeat (RESET_HOLD) @(negedge clk);
   endtask

   task automatic test_random();
      logic [6:0] exp_w;
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      m_hold_left = RESET_HOLD; m_wait = 1'b0; m_stall = '0; m_flush = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         LoadE      = 1'($urandom_range(0, 1));
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         PCSrcE     = ($urandom_range(0, 5) == 0);
         imem_ready = ($urandom_range(0, 3) != 0);
         dmem_req   = 1'($urandom_range(0, 1));
         dmem_ready = ($urandom_range(0, 2) == 0);
         #1;
         model_eval();
         exp_q.push_back(exp_ctl);
         exp_w = exp_q.pop_front();
         n_tests++; if (ctl !== exp_w) begin n_fail++; $display("FAIL rnd_ctl c%0d: got %b want %b", cyc, ctl, exp_w); end
         n_tests++; if (ForwardAE !== exp_fa || ForwardBE !== exp_fb) begin n_fail++; $display("FAIL rnd_fwd c%0d: got %b/%b want %b/%b", cyc, ForwardAE, ForwardBE, exp_fa, exp_fb); end
         n_tests++; if (state_o !== exp_state) begin n_fail++; $display("FAIL rnd_state c%0d: got %0d want %0d", cyc, state_o, exp_state); end
         n_tests++; if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", cyc, stall_cnt, flush_cnt, m_stall, m_flush); end
         @(posedge clk);
         model_clock();
         @(negedge clk);
      end
      set_idle();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_branch();
      test_data_wait();
      test_forward();
      test_async_reset_dwait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
